// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_if
// Purpose  : Data-memory request/acknowledge port between the memory-stage
//            access controller and the data memory.
//
// Signals (named from the controller's point of view)
//   o_dm_req    1       request, held high until acknowledged
//   o_dm_we     1       1=write, 0=read; valid while o_dm_req
//   o_dm_addr   ADDR_W  request address, stable while o_dm_req
//   o_dm_wdata  DATA_W  store data, stable while o_dm_req
//   i_dm_ack    1       completion pulse (one cycle)
//   i_dm_rdata  DATA_W  read data, valid with i_dm_ack
//
// Modports
//   master : controller side (drives request, receives completion)
//   slave  : memory side (receives request, drives completion)
//
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();

  logic              o_dm_req;
  logic              o_dm_we;
  logic [ADDR_W-1:0] o_dm_addr;
  logic [DATA_W-1:0] o_dm_wdata;
  logic              i_dm_ack;
  logic [DATA_W-1:0] i_dm_rdata;

  modport master (
    output o_dm_req,
    output o_dm_we,
    output o_dm_addr,
    output o_dm_wdata,
    input  i_dm_ack,
    input  i_dm_rdata
  );

  modport slave (
    input  o_dm_req,
    input  o_dm_we,
    input  o_dm_addr,
    input  o_dm_wdata,
    output i_dm_ack,
    output i_dm_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : Memory-stage access controller sitting between the EX/MEM pipe
//            register and mem_wb_reg. Converts the per-instruction load/store
//            controls into a req/ack transaction on the data-memory port,
//            stalls the pipeline while the access is outstanding and presents
//            the last completed load data to mem_wb_reg.
//
// Parameters
//   DATA_W    data bus width
//   ADDR_W    data-memory address width
//   MAX_WAIT  REQ-state cycles before timeout (timeout build only), >= 1
//
// Ports
//   clk         in   pipeline clock, all state updates on posedge
//   rst_n       in   asynchronous active-low reset
//   i_mem_rd    in   instruction in MEM is a load
//   i_mem_wrt   in   instruction in MEM is a store
//   i_addr      in   effective address (ALU result)
//   i_wdata     in   store data
//   dm          if   data-memory port (master modport of mem_stage_ctrl_if)
//   o_mem_data  out  last completed load data, to mem_wb_reg
//   o_stall     out  freeze PC/IF/ID/EX/MEM regs; also clears mem_wb_reg
//   o_err       out  one-cycle timeout pulse
//
// Build option
//   MEM_TIMEOUT_EN : when defined, a request that stays unacknowledged for
//                    MAX_WAIT cycles is abandoned and flagged on o_err.
//                    When undefined, REQ waits for ack indefinitely and
//                    o_err is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_mem_rd,
  input  wire logic              i_mem_wrt,
  input  wire logic [ADDR_W-1:0] i_addr,
  input  wire logic [DATA_W-1:0] i_wdata,
  mem_stage_ctrl_if.master       dm,
  output logic      [DATA_W-1:0] o_mem_data,
  output logic                   o_stall,
  output logic                   o_err
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_req;
  logic              w_req_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] w_mem_data_nxt;

  logic              w_mem_op;

`ifdef MEM_TIMEOUT_EN
  localparam int c_CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  // Counter value seen during the last permitted REQ cycle.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic [c_CNT_W-1:0] w_wait_cnt_nxt;
  logic               r_err;
  logic               w_err_nxt;
`endif

  assign w_mem_op = i_mem_rd | i_mem_wrt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Request / data registers. The async clear drops an outstanding request
  // the moment rst_n falls, without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_data <= '0;
    end else begin
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_mem_data <= w_mem_data_nxt;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and next-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_mem_data_nxt = r_mem_data;
`ifdef MEM_TIMEOUT_EN
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_nxt      = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        // Acks arriving here are not ours and are ignored.
        if (w_mem_op) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
          // A store takes priority when both controls are raised.
          w_we_nxt    = i_mem_wrt;
          w_addr_nxt  = i_addr;
          w_wdata_nxt = i_wdata;
`ifdef MEM_TIMEOUT_EN
          w_wait_cnt_nxt = '0;
`endif
        end
      end

      S_REQ: begin
        if (dm.i_dm_ack) begin
          w_state_nxt = S_DONE;
          w_req_nxt   = 1'b0;
          if (!r_we) begin
            w_mem_data_nxt = dm.i_dm_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (r_wait_cnt == c_CNT_LAST) begin
          // Abandon the access; a timed-out load returns zero.
          w_state_nxt = S_DONE;
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          if (!r_we) begin
            w_mem_data_nxt = '0;
          end
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_CNT_W'(1);
        end
`endif
      end

      S_DONE: begin
        // Single release cycle so the pipeline can advance to the next
        // instruction before it is sampled in IDLE.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Stall is raised combinationally in the IDLE cycle that sees a memory op
  // so the instruction is held while the request is launched; non-memory
  // instructions see no added latency.
  assign o_stall = (r_state == S_REQ) | ((r_state == S_IDLE) & w_mem_op);

  assign dm.o_dm_req   = r_req;
  assign dm.o_dm_we    = r_we;
  assign dm.o_dm_addr  = r_addr;
  assign dm.o_dm_wdata = r_wdata;
  assign o_mem_data    = r_mem_data;

`ifdef MEM_TIMEOUT_EN
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Invariants
  // --------------------------------------------------------------------------
  a_max_wait_legal : assert property (@(posedge clk) MAX_WAIT >= 1);

  // The request line is high exactly while the FSM sits in REQ.
  a_req_in_req : assert property (@(posedge clk) disable iff (!rst_n)
    r_req == (r_state == S_REQ));

  // Address, data and direction hold while the request is outstanding.
  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (r_req && !dm.i_dm_ack && (r_state == S_REQ) && (w_state_nxt == S_REQ))
      |=> ($stable(r_addr) && $stable(r_wdata) && $stable(r_we)));

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Self-checking bench for mem_stage_ctrl. Directed table vectors,
//            hand-written reset / spurious-ack / timeout sequences and
//            randomized memory and non-memory instructions checked against a
//            transaction-level model (stall = waits+2, req = waits+1, loads
//            update the returned data, stores leave it alone).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  localparam int c_DW       = 16;
  localparam int c_AW       = 16;
  localparam int c_MAX_WAIT = 15;

  logic            clk;
  logic            rst_n;
  logic            mem_rd;
  logic            mem_wrt;
  logic [c_AW-1:0] addr;
  logic [c_DW-1:0] wdata;
  logic [c_DW-1:0] mem_data;
  logic            stall;
  logic            err;

  mem_stage_ctrl_if #(.DATA_W(c_DW), .ADDR_W(c_AW)) dm_if ();

  mem_stage_ctrl #(
    .DATA_W  (c_DW),
    .ADDR_W  (c_AW),
    .MAX_WAIT(c_MAX_WAIT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_mem_rd  (mem_rd),
    .i_mem_wrt (mem_wrt),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .dm        (dm_if),
    .o_mem_data(mem_data),
    .o_stall   (stall),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Watchdog so a hung DUT still ends the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One memory instruction from its IDLE cycle through DONE. The bench acts
  // as the memory: ack is raised in the (waits+1)-th cycle that req is seen.
  // Entered and left at posedge+1.
  task automatic run_op(input logic rd, input logic wrt,
                        input logic [c_AW-1:0] a, input logic [c_DW-1:0] wd,
                        input int waits, input logic [c_DW-1:0] rdata,
                        output int stall_c, output int req_c,
                        output bit stable_ok, output logic [c_DW-1:0] md_done,
                        output bit err_seen, output bit done_ok);
    stall_c   = 0;
    req_c     = 0;
    stable_ok = 1'b1;
    err_seen  = 1'b0;
    done_ok   = 1'b0;
    md_done   = 'x;
    for (int cyc = 0; cyc < 40; cyc++) begin
      mem_rd          = rd;
      mem_wrt         = wrt;
      addr            = a;
      wdata           = wd;
      dm_if.i_dm_ack  = 1'b0;
      #1;
      if (err) err_seen = 1'b1;
      if (dm_if.o_dm_req) begin
        req_c++;
        if (dm_if.o_dm_addr !== a || dm_if.o_dm_wdata !== wd || dm_if.o_dm_we !== wrt)
          stable_ok = 1'b0;
        if (req_c == waits + 1) begin
          dm_if.i_dm_ack   = 1'b1;
          dm_if.i_dm_rdata = rdata;
        end
      end
      if (stall) begin
        stall_c++;
      end else if (cyc > 0) begin
        md_done = mem_data;
        done_ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (done_ok) break;
    end
    dm_if.i_dm_ack = 1'b0;
    mem_rd         = 1'b0;
    mem_wrt        = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    mem_rd         = 1'b0;
    mem_wrt        = 1'b0;
    addr           = c_AW'($urandom);
    dm_if.i_dm_ack = 1'b0;
    #1;
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_req"}, dm_if.o_dm_req, 1'b0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int              gap;
    logic            rd;
    logic            wrt;
    logic [c_AW-1:0] a;
    logic [c_DW-1:0] wd;
    int              waits;
    logic [c_DW-1:0] rdata;
    int              exp_stall;
    int              exp_req;
    logic [c_DW-1:0] exp_md;
  } vec_t;

  vec_t vecs[5];

  logic [c_DW-1:0] model_md;
  int              st_c, rq_c;
  bit              stab, errs, dn;
  logic [c_DW-1:0] md;

  initial begin
    // load, ack in first REQ cycle
    vecs[0] = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 2, 1, 16'hBEEF};
    // store, ack in third REQ cycle; load data untouched
    vecs[1] = '{0, 1'b0, 1'b1, 16'h0040, 16'h1234, 2, 16'h7777, 4, 3, 16'hBEEF};
    // non-memory instructions, then two loads back to back
    vecs[2] = '{3, 1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h0A0A, 3, 2, 16'h0A0A};
    vecs[3] = '{0, 1'b1, 1'b0, 16'h0102, 16'h0000, 0, 16'h5555, 2, 1, 16'h5555};
    // rd and wrt both high: handled as a store
    vecs[4] = '{1, 1'b1, 1'b1, 16'h0200, 16'hCAFE, 0, 16'h9999, 2, 1, 16'h5555};

    rst_n            = 1'b0;
    mem_rd           = 1'b0;
    mem_wrt          = 1'b0;
    addr             = '0;
    wdata            = '0;
    dm_if.i_dm_ack   = 1'b0;
    dm_if.i_dm_rdata = '0;

    // ---------------- reset state ----------------
    @(posedge clk);
    #1;
    chk("rst_req", dm_if.o_dm_req, 1'b0);
    chk("rst_we", dm_if.o_dm_we, 1'b0);
    chk("rst_addr", dm_if.o_dm_addr, 16'h0);
    chk("rst_wdata", dm_if.o_dm_wdata, 16'h0);
    chk("rst_mem_data", mem_data, 16'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < vecs[i].gap; g++) idle_cycle("vec_gap");
      run_op(vecs[i].rd, vecs[i].wrt, vecs[i].a, vecs[i].wd, vecs[i].waits,
             vecs[i].rdata, st_c, rq_c, stab, md, errs, dn);
      chk($sformatf("vec%0d_done", i), dn, 1'b1);
      chk($sformatf("vec%0d_stall_cycles", i), st_c, vecs[i].exp_stall);
      chk($sformatf("vec%0d_req_cycles", i), rq_c, vecs[i].exp_req);
      chk($sformatf("vec%0d_bus_stable", i), stab, 1'b1);
      chk($sformatf("vec%0d_mem_data", i), md, vecs[i].exp_md);
      chk($sformatf("vec%0d_err", i), errs, 1'b0);
    end
    model_md = 16'h5555;

    // ---------------- spurious ack in IDLE ----------------
    mem_rd           = 1'b0;
    mem_wrt          = 1'b0;
    dm_if.i_dm_ack   = 1'b1;
    dm_if.i_dm_rdata = 16'hDEAD;
    #1;
    chk("spur_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    dm_if.i_dm_ack = 1'b0;
    chk("spur_req", dm_if.o_dm_req, 1'b0);
    chk("spur_mem_data", mem_data, model_md);
    idle_cycle("spur_after");
    run_op(1'b1, 1'b1, 16'h0300, 16'hA5A5, 1, 16'h1111, st_c, rq_c, stab, md, errs, dn);
    chk("spur_rdwr_we_stable", stab, 1'b1);
    chk("spur_rdwr_stall", st_c, 3);
    chk("spur_rdwr_mem_data", md, model_md);

    // ---------------- async reset while in REQ ----------------
    mem_rd = 1'b1;
    addr   = 16'h0404;
    @(posedge clk);
    #1;
    mem_rd = 1'b0;
    chk("arst_req_before", dm_if.o_dm_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_now", dm_if.o_dm_req, 1'b0);
    chk("arst_mem_data_now", mem_data, 16'h0);
    model_md = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle("arst_idle");
    run_op(1'b1, 1'b0, 16'h0500, 16'h0, 0, 16'h2468, st_c, rq_c, stab, md, errs, dn);
    chk("arst_next_stall", st_c, 2);
    chk("arst_next_mem_data", md, 16'h2468);
    model_md = 16'h2468;

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < $urandom_range(1, 3); g++) idle_cycle("rnd_nonmem");
      end else begin
        logic            r_rd, r_wr;
        logic [c_AW-1:0] r_a;
        logic [c_DW-1:0] r_wd, r_rdat;
        int              r_w;
        int              sel;
        sel    = $urandom_range(0, 2);
        r_rd   = (sel != 1);
        r_wr   = (sel != 0);
        r_a    = c_AW'($urandom);
        r_wd   = c_DW'($urandom);
        r_rdat = c_DW'($urandom);
        r_w    = $urandom_range(0, 5);
        run_op(r_rd, r_wr, r_a, r_wd, r_w, r_rdat, st_c, rq_c, stab, md, errs, dn);
        if (r_rd && !r_wr) model_md = r_rdat;
        chk("rnd_done", dn, 1'b1);
        chk("rnd_stall_cycles", st_c, r_w + 2);
        chk("rnd_req_cycles", rq_c, r_w + 1);
        chk("rnd_bus_stable", stab, 1'b1);
        chk("rnd_mem_data", md, model_md);
        chk("rnd_err", errs, 1'b0);
      end
    end

    // ---------------- unacknowledged load ----------------
    begin
      int  req_c;
      bit  dropped;
      mem_rd  = 1'b1;
      addr    = 16'h0600;
      req_c   = 0;
      dropped = 1'b0;
`ifdef MEM_TIMEOUT_EN
      for (int cyc = 0; cyc < 100; cyc++) begin
        #1;
        if (dm_if.o_dm_req) req_c++;
        else if (cyc > 0) begin
          dropped = 1'b1;
          chk("to_err_pulse", err, 1'b1);
          chk("to_mem_data", mem_data, 16'h0);
          chk("to_stall_done", stall, 1'b0);
        end
        @(posedge clk);
        #1;
        if (dropped) break;
      end
      mem_rd = 1'b0;
      chk("to_dropped", dropped, 1'b1);
      chk("to_req_cycles", req_c, c_MAX_WAIT);
      // late ack after the timeout
      dm_if.i_dm_ack   = 1'b1;
      dm_if.i_dm_rdata = 16'hFACE;
      #1;
      chk("to_err_cleared", err, 1'b0);
      chk("to_late_ack_stall", stall, 1'b0);
      @(posedge clk);
      #1;
      dm_if.i_dm_ack = 1'b0;
      chk("to_late_ack_req", dm_if.o_dm_req, 1'b0);
      chk("to_late_ack_mem_data", mem_data, 16'h0);
`else
      for (int cyc = 0; cyc < 100; cyc++) begin
        #1;
        if (dm_if.o_dm_req) req_c++;
        chk("noto_err", err, 1'b0);
        @(posedge clk);
        #1;
      end
      #1;
      chk("noto_stall_at_100", stall, 1'b1);
      chk("noto_req_at_100", dm_if.o_dm_req, 1'b1);
      chk("noto_req_cycles", req_c, 99);
      mem_rd = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("noto_reset_drop", dm_if.o_dm_req, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
